// File: rtl/lab7_defs.sv
// ============================================================================
// lab7_defs : shared bus encodings, widths and default I/O addresses
// Rev 1.0
// ============================================================================
`default_nettype none

package lab7_defs;

   localparam int ADDR_W = 9;
   localparam int DATA_W = 16;

   typedef enum logic [1:0] {
      MNONE  = 2'd0,
      MREAD  = 2'd1,
      MWRITE = 2'd2
   } mem_cmd_e;

   localparam logic [ADDR_W-1:0] DEF_LED_ADDR  = 9'h100;
   localparam logic [ADDR_W-1:0] DEF_SW_ADDR   = 9'h140;
   localparam logic [ADDR_W-1:0] DEF_EDGE_ADDR = 9'h141;
   localparam logic [ADDR_W-1:0] DEF_CNT_ADDR  = 9'h142;

endpackage

`default_nettype wire

// File: rtl/sync_edge_det.sv
// ============================================================================
// sync_edge_det : WIDTH-bit 2-flop synchronizer with falling-edge pulse output
// Rev 1.0
// ============================================================================
`default_nettype none

module sync_edge_det #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] async_in,
   output logic [WIDTH-1:0] sync_out,
   output logic [WIDTH-1:0] fall_pulse
);

   logic [WIDTH-1:0] meta;
   logic [WIDTH-1:0] sync_q;
   logic [WIDTH-1:0] prev_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta   <= RESET_VAL;
         sync_q <= RESET_VAL;
         prev_q <= RESET_VAL;
      end else begin
         meta   <= async_in;
         sync_q <= meta;
         prev_q <= sync_q;
      end
   end

   assign sync_out   = sync_q;
   // High for the one cycle after the synchronized value drops.
   assign fall_pulse = prev_q & ~sync_q;

endmodule

`default_nettype wire

// File: rtl/lab7_io_responder.sv
// ============================================================================
// lab7_io_responder : memory-mapped I/O slave (LEDs, switches, key edge flags,
// optional cycle counter built when IO_CYCLE_COUNTER_EN is defined)
// Rev 1.0
// ============================================================================
`default_nettype none

module lab7_io_responder
   import lab7_defs::*;
#(
   parameter logic [ADDR_W-1:0] LED_ADDR  = DEF_LED_ADDR,
   parameter logic [ADDR_W-1:0] SW_ADDR   = DEF_SW_ADDR,
   parameter logic [ADDR_W-1:0] EDGE_ADDR = DEF_EDGE_ADDR,
   parameter logic [ADDR_W-1:0] CNT_ADDR  = DEF_CNT_ADDR
) (
   input  logic              clk,
   input  logic              reset_n,
   input  mem_cmd_e          mem_cmd,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] write_data,
   output logic [DATA_W-1:0] read_data,
   output logic              rd_valid,
   output logic              io_sel,
   input  logic [9:0]        sw_in,
   input  logic [1:0]        key_n_in,
   output logic [7:0]        led_out
);

   logic [9:0]        sw_sync;
   logic [9:0]        sw_fall_unused;
   logic [1:0]        key_sync_unused;
   logic [1:0]        key_fall;
   logic [1:0]        flags;
   logic [1:0]        flag_clr;
   logic [DATA_W-1:0] count_val;
   logic [DATA_W-1:0] rd_mux;
   logic              hit_led, hit_sw, hit_edge, hit_cnt, hit_any;
   logic              is_rd, is_wr;

   sync_edge_det #(.WIDTH(10), .RESET_VAL(10'h000)) u_sw_sync (
      .clk        (clk),
      .reset_n    (reset_n),
      .async_in   (sw_in),
      .sync_out   (sw_sync),
      .fall_pulse (sw_fall_unused)
   );

   sync_edge_det #(.WIDTH(2), .RESET_VAL(2'b11)) u_key_sync (
      .clk        (clk),
      .reset_n    (reset_n),
      .async_in   (key_n_in),
      .sync_out   (key_sync_unused),
      .fall_pulse (key_fall)
   );

`ifdef IO_CYCLE_COUNTER_EN
   logic [DATA_W-1:0] count_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) count_q <= '0;
      else          count_q <= count_q + 1'b1;
   end

   assign hit_cnt   = (mem_addr == CNT_ADDR);
   assign count_val = count_q;
   wire   unused_ok = &{1'b0, write_data[DATA_W-1:8]};
`else
   assign hit_cnt   = 1'b0;
   assign count_val = '0;
   wire   unused_ok = &{1'b0, write_data[DATA_W-1:8], CNT_ADDR};
`endif

   assign hit_led  = (mem_addr == LED_ADDR);
   assign hit_sw   = (mem_addr == SW_ADDR);
   assign hit_edge = (mem_addr == EDGE_ADDR);
   assign hit_any  = hit_led | hit_sw | hit_edge | hit_cnt;
   assign is_rd    = (mem_cmd == MREAD);
   assign is_wr    = (mem_cmd == MWRITE);
   assign io_sel   = (mem_cmd != MNONE) && hit_any;

   always_comb begin
      rd_mux = '0;
      if (hit_sw)        rd_mux = {6'b0, sw_sync};
      else if (hit_edge) rd_mux = {14'b0, flags};
      else if (hit_led)  rd_mux = {8'b0, led_out};
      else if (hit_cnt)  rd_mux = count_val;
   end

   always_comb begin
      flag_clr = 2'b00;
      if (hit_edge && is_rd)      flag_clr = 2'b11;
      else if (hit_edge && is_wr) flag_clr = write_data[1:0];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         led_out   <= '0;
         flags     <= '0;
         read_data <= '0;
         rd_valid  <= 1'b0;
      end else begin
         // A press landing in the same cycle as a clear keeps its flag.
         flags    <= (flags & ~flag_clr) | key_fall;
         rd_valid <= is_rd && hit_any;
         if (is_rd && hit_any) read_data <= rd_mux;
         if (is_wr && hit_led) led_out   <= write_data[7:0];
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_lab7_io_responder.sv
// ============================================================================
// tb_lab7_io_responder : directed scoreboard bench for lab7_io_responder
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_lab7_io_responder;
   import lab7_defs::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   mem_cmd_e    mem_cmd = MNONE;
   logic [8:0]  mem_addr = '0;
   logic [15:0] write_data = '0;
   logic [15:0] read_data;
   logic        rd_valid;
   logic        io_sel;
   logic [9:0]  sw_in = '0;
   logic [1:0]  key_n_in = 2'b11;
   logic [7:0]  led_out;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] sb[$];
   logic [15:0] model_cnt;

   lab7_io_responder dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .mem_cmd    (mem_cmd),
      .mem_addr   (mem_addr),
      .write_data (write_data),
      .read_data  (read_data),
      .rd_valid   (rd_valid),
      .io_sel     (io_sel),
      .sw_in      (sw_in),
      .key_n_in   (key_n_in),
      .led_out    (led_out)
   );

   always #5 clk = ~clk;

   // Reference cycle count: zero in reset, +1 on every edge afterwards.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) model_cnt <= '0;
      else          model_cnt <= model_cnt + 16'd1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at posedge+1; drives one bus cycle and checks its result after the edge.
   task automatic bus(input string tag, input mem_cmd_e c, input logic [8:0] a,
                      input logic [15:0] wd, input logic exp_sel, input logic exp_rd,
                      input logic [15:0] exp_data);
      logic [15:0] e;
      mem_cmd    = c;
      mem_addr   = a;
      write_data = wd;
      if (exp_rd) sb.push_back(exp_data);
      #1;
      chk({tag, ":io_sel"}, 32'(io_sel), 32'(exp_sel));
      @(posedge clk);
      #1;
      chk({tag, ":rd_valid"}, 32'(rd_valid), 32'(exp_rd));
      if (rd_valid === 1'b1) begin
         chk({tag, ":sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, ":read_data"}, 32'(read_data), 32'(e));
         end
      end else if (exp_rd && sb.size() > 0) begin
         void'(sb.pop_front());
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) bus("idle", MNONE, 9'h000, 16'h0000, 1'b0, 1'b0, 16'h0000);
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst:led_out", 32'(led_out), 32'h0);
      chk("rst:read_data", 32'(read_data), 32'h0);
      chk("rst:rd_valid", 32'(rd_valid), 32'h0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      bus("rst_edge", MREAD, 9'h141, 16'h0, 1'b1, 1'b1, 16'h0000);

      // LED write, read-back, ignored writes to read-only addresses
      bus("led_wr", MWRITE, 9'h100, 16'hABCD, 1'b1, 1'b0, 16'h0);
      chk("led_out", 32'(led_out), 32'hCD);
      bus("led_rd", MREAD, 9'h100, 16'h0, 1'b1, 1'b1, 16'h00CD);
      bus("sw_wr", MWRITE, 9'h140, 16'hFFFF, 1'b1, 1'b0, 16'h0);
      bus("led_rd2", MREAD, 9'h100, 16'h0, 1'b1, 1'b1, 16'h00CD);
      chk("led_hold", 32'(led_out), 32'hCD);

      // Switches, then read_data holds between reads
      sw_in = 10'h2A5;
      idle(3);
      bus("sw_rd", MREAD, 9'h140, 16'h0, 1'b1, 1'b1, 16'h02A5);
      idle(1);
      chk("rd_hold", 32'(read_data), 32'h02A5);

      // Key 1 press, read-to-clear, back-to-back reads
      key_n_in = 2'b01;
      idle(4);
      key_n_in = 2'b11;
      idle(2);
      bus("edge_rd1", MREAD, 9'h141, 16'h0, 1'b1, 1'b1, 16'h0002);
      bus("edge_rd2", MREAD, 9'h141, 16'h0, 1'b1, 1'b1, 16'h0000);

      // Press lands in the same cycle as the clearing read: set wins
      key_n_in = 2'b01;
      idle(2);
      bus("coinc_rd", MREAD, 9'h141, 16'h0, 1'b1, 1'b1, 16'h0000);
      bus("coinc_rd2", MREAD, 9'h141, 16'h0, 1'b1, 1'b1, 16'h0002);
      bus("coinc_rd3", MREAD, 9'h141, 16'h0, 1'b1, 1'b1, 16'h0000);
      key_n_in = 2'b11;
      idle(3);

      // Both keys pressed, write-1-to-clear of bit 0 only
      key_n_in = 2'b00;
      idle(4);
      key_n_in = 2'b11;
      bus("w1c", MWRITE, 9'h141, 16'h0001, 1'b1, 1'b0, 16'h0);
      bus("w1c_rd", MREAD, 9'h141, 16'h0, 1'b1, 1'b1, 16'h0002);
      bus("w1c_rd2", MREAD, 9'h141, 16'h0, 1'b1, 1'b1, 16'h0000);

`ifdef IO_CYCLE_COUNTER_EN
      bus("cnt_rd0", MREAD, 9'h142, 16'h0, 1'b1, 1'b1, model_cnt);
      bus("cnt_rd1", MREAD, 9'h142, 16'h0, 1'b1, 1'b1, model_cnt);
      bus("cnt_wr", MWRITE, 9'h142, 16'h1234, 1'b1, 1'b0, 16'h0);
      for (int i = 0; i < 70000 && model_cnt != 16'hFFFE; i++) begin
         @(posedge clk);
         #1;
      end
      bus("cnt_fffe", MREAD, 9'h142, 16'h0, 1'b1, 1'b1, 16'hFFFE);
      bus("cnt_ffff", MREAD, 9'h142, 16'h0, 1'b1, 1'b1, 16'hFFFF);
      bus("cnt_wrap", MREAD, 9'h142, 16'h0, 1'b1, 1'b1, 16'h0000);
`else
      bus("cnt_off_rd", MREAD, 9'h142, 16'h0, 1'b0, 1'b0, 16'h0);
      bus("cnt_off_wr", MWRITE, 9'h142, 16'h1234, 1'b0, 1'b0, 16'h0);
`endif

      // Misses to a non-I/O address leave state alone
      bus("miss_rd", MREAD, 9'h050, 16'h0, 1'b0, 1'b0, 16'h0);
      bus("miss_wr", MWRITE, 9'h050, 16'h00FF, 1'b0, 1'b0, 16'h0);
      bus("miss_led", MREAD, 9'h100, 16'h0, 1'b1, 1'b1, 16'h00CD);

      // Asynchronous reset while a read result is on the bus
      mem_cmd = MNONE;
      #2 reset_n = 1'b0;
      #1;
      chk("arst:rd_valid", 32'(rd_valid), 32'h0);
      chk("arst:read_data", 32'(read_data), 32'h0);
      chk("arst:led_out", 32'(led_out), 32'h0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      bus("post_rst_led", MREAD, 9'h100, 16'h0, 1'b1, 1'b1, 16'h0000);
      bus("post_rst_edge", MREAD, 9'h141, 16'h0, 1'b1, 1'b1, 16'h0000);

      chk("sb_drained", 32'(sb.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
